uart_job_dispatch: RTL and testbench



---
 rtl/uart_proto_pkg.sv | 17 +
 rtl/crc32.sv | 23 ++
 rtl/uart_resp_parser.sv | 77 +++++++
 rtl/uart_job_dispatch.sv | 158 +++++++++++++++
 tb/tb_uart_job_dispatch.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_proto_pkg.sv
// Shared message codes, frame geometry and state/event types for the miner UART packet protocol.
package uart_proto_pkg;
  localparam logic [7:0] MSG_INFO     = 8'd0;
  localparam logic [7:0] MSG_INVALID  = 8'd1;
  localparam logic [7:0] MSG_PUSH_JOB = 8'd2;
  localparam logic [7:0] MSG_NONCE    = 8'd3;
  localparam logic [7:0] MSG_ACK      = 8'd4;
  localparam logic [7:0] MSG_RESEND   = 8'd5;

  localparam int JOB_SIZE     = 416;
  localparam int PUSH_JOB_LEN = 60;
  localparam int HDR_LEN      = 4;
  localparam int CRC_LEN      = 4;

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP, TX_WAIT_RESP} tx_state_t;
  typedef enum logic [1:0] {EV_NONE, EV_ACK, EV_RESEND, EV_INVALID} resp_event_t;
endpackage

// File: rtl/crc32.sv
// Shared CRC32 engine: poly 04C11DB7, init all-ones, MSB first, no final xor,
// so a receiver running it over payload plus appended CRC ends at zero.
module crc32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        valid,
  input  logic [7:0]  data,
  output logic [31:0] crc
);
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--)
      r = (r[31] ^ d[i]) ? ({r[30:0], 1'b0} ^ 32'h04C11DB7) : {r[30:0], 1'b0};
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || clear) crc <= 32'hFFFF_FFFF;
    else if (valid)     crc <= crc_byte(crc, data);
  end
endmodule

// File: rtl/uart_resp_parser.sv
// Response-frame parser: length-prefixed framing, inter-byte gap abort, and
// registered one-cycle event / nonce outputs.
module uart_resp_parser
  import uart_proto_pkg::*;
#(
  parameter int RX_GAP_TIMEOUT = 20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        received,
  input  logic [7:0]  rx_byte,
  output resp_event_t resp_evt,
  output logic        nonce_valid,
  output logic [31:0] nonce
);
  logic [7:0]  count;
  logic [7:0]  len;
  logic [7:0]  msg_type;
  logic [23:0] nonce_sr;
  logic [31:0] gap;
  logic [7:0]  type_now;
  logic        last;

  // The type byte may arrive on the very cycle the frame completes.
  always_comb begin
    type_now = (count == 8'd3) ? rx_byte : msg_type;
    last     = (count != 8'd0) && ((count + 8'd1) == len);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= 8'd0;
      len         <= 8'd0;
      msg_type    <= 8'd0;
      nonce_sr    <= 24'd0;
      gap         <= 32'd0;
      resp_evt    <= EV_NONE;
      nonce_valid <= 1'b0;
      nonce       <= 32'd0;
    end else begin
      resp_evt    <= EV_NONE;
      nonce_valid <= 1'b0;
      if (received) begin
        gap <= 32'd0;
        if (count == 8'd0) begin
          if (rx_byte == 8'd1)       resp_evt <= EV_ACK;
          else if (rx_byte != 8'd0) begin
            len   <= rx_byte;
            count <= 8'd1;
          end
        end else begin
          count    <= last ? 8'd0 : count + 8'd1;
          nonce_sr <= {nonce_sr[15:0], rx_byte};
          if (count == 8'd3) msg_type <= rx_byte;
          if (last && count >= 8'd3) begin
            case (type_now)
              MSG_RESEND:  resp_evt <= EV_RESEND;
              MSG_INVALID: resp_evt <= EV_INVALID;
              MSG_NONCE: if (len == 8'd8) begin
                nonce       <= {nonce_sr, rx_byte};
                nonce_valid <= 1'b1;
              end
              default: ;
            endcase
          end
        end
      end else if (count != 8'd0) begin
        if (gap == 32'(RX_GAP_TIMEOUT - 1)) begin
          count <= 8'd0;
          gap   <= 32'd0;
        end else begin
          gap <= gap + 32'd1;
        end
      end
    end
  end
endmodule

// File: rtl/uart_job_dispatch.sv
// Host side of the miner UART protocol: frames a job as MSG_PUSH_JOB with CRC32 and retries on RESEND/timeout.
// Optional retry statistics are enabled by defining UART_JOB_DISPATCH_STATS_EN.
module uart_job_dispatch #(
  parameter int JOB_SIZE       = 416,
  parameter int MAX_RETRIES    = 3,
  parameter int RESP_TIMEOUT   = 200000,
  parameter int RX_GAP_TIMEOUT = 20000
) (
  input  logic                comm_clk,
  input  logic                reset,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [JOB_SIZE-1:0] job,
  output logic [7:0]          tx_byte,
  output logic                transmit,
  input  logic                is_transmitting,
  input  logic                received,
  input  logic [7:0]          rx_byte,
  output logic                nonce_valid,
  output logic [31:0]         nonce,
  output logic                job_acked,
  output logic                job_failed,
  output logic [15:0]         stat_retries
);
  import uart_proto_pkg::*;

  localparam logic [5:0] FRAME_END = 6'(PUSH_JOB_LEN);
  localparam logic [5:0] CRC_POS   = 6'(PUSH_JOB_LEN - CRC_LEN);

  tx_state_t          state, state_next;
  logic [JOB_SIZE-1:0] job_q;
  logic [5:0]          idx, idx_next;
  logic [7:0]          retries, retries_next;
  logic [31:0]         timer, timer_next;
  logic                send_now, retry_now, acked_next, failed_next, crc_clear;
  logic [7:0]          frame_byte;
  logic [8:0]          pay_bit;
  logic [31:0]         crc;
  resp_event_t         resp_evt;

  uart_resp_parser #(.RX_GAP_TIMEOUT(RX_GAP_TIMEOUT)) u_parser (
    .clk(comm_clk), .reset(reset), .received(received), .rx_byte(rx_byte),
    .resp_evt(resp_evt), .nonce_valid(nonce_valid), .nonce(nonce)
  );

  // CRC restarts whenever a frame (first or retried) begins from byte 0.
  assign crc_clear = (state == TX_IDLE) || retry_now;

  crc32 u_crc (
    .clk(comm_clk), .reset(reset), .clear(crc_clear),
    .valid(send_now && (idx < CRC_POS)), .data(frame_byte), .crc(crc)
  );

  always_comb begin
    pay_bit = {idx - 6'd4, 3'b000};
    case (idx)
      6'd0:            frame_byte = 8'(PUSH_JOB_LEN);
      6'd1, 6'd2:      frame_byte = 8'h00;
      6'd3:            frame_byte = MSG_PUSH_JOB;
      CRC_POS:         frame_byte = crc[31:24];
      CRC_POS + 6'd1:  frame_byte = crc[23:16];
      CRC_POS + 6'd2:  frame_byte = crc[15:8];
      CRC_POS + 6'd3:  frame_byte = crc[7:0];
      default:         frame_byte = (idx < CRC_POS) ? job_q[pay_bit +: 8] : 8'h00;
    endcase
  end

  always_comb begin
    state_next   = state;
    idx_next     = idx;
    retries_next = retries;
    timer_next   = timer;
    send_now     = 1'b0;
    retry_now    = 1'b0;
    acked_next   = 1'b0;
    failed_next  = 1'b0;
    case (state)
      TX_IDLE: if (job_valid && job_ready) begin
        idx_next     = 6'd0;
        retries_next = 8'd0;
        state_next   = TX_SEND;
      end
      TX_SEND: if (!is_transmitting) begin
        send_now   = 1'b1;
        idx_next   = idx + 6'd1;
        state_next = TX_GAP;
      end
      TX_GAP: begin
        if (idx == FRAME_END) begin
          timer_next = 32'd0;
          state_next = TX_WAIT_RESP;
        end else begin
          state_next = TX_SEND;
        end
      end
      TX_WAIT_RESP: begin
        timer_next = timer + 32'd1;
        if (resp_evt == EV_ACK) begin
          acked_next = 1'b1;
          state_next = TX_IDLE;
        end else if (resp_evt == EV_INVALID) begin
          failed_next = 1'b1;
          state_next  = TX_IDLE;
        end else if (resp_evt == EV_RESEND || timer == 32'(RESP_TIMEOUT)) begin
          if (retries < 8'(MAX_RETRIES)) begin
            retry_now    = 1'b1;
            retries_next = retries + 8'd1;
            idx_next     = 6'd0;
            state_next   = TX_SEND;
          end else begin
            failed_next = 1'b1;
            state_next  = TX_IDLE;
          end
        end
      end
      default: state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge comm_clk) begin
    if (reset) begin
      state      <= TX_IDLE;
      idx        <= 6'd0;
      retries    <= 8'd0;
      timer      <= 32'd0;
      tx_byte    <= 8'h00;
      transmit   <= 1'b0;
      job_ready  <= 1'b0;
      job_acked  <= 1'b0;
      job_failed <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      retries    <= retries_next;
      timer      <= timer_next;
      transmit   <= send_now;
      if (send_now) tx_byte <= frame_byte;
      job_ready  <= (state_next == TX_IDLE);
      job_acked  <= acked_next;
      job_failed <= failed_next;
    end
  end

  always_ff @(posedge comm_clk) begin
    if (state == TX_IDLE && job_valid && job_ready) job_q <= job;
  end

`ifdef UART_JOB_DISPATCH_STATS_EN
  logic [15:0] stat_q;
  always_ff @(posedge comm_clk) begin
    if (reset)                              stat_q <= 16'd0;
    else if (retry_now && stat_q != 16'hFFFF) stat_q <= stat_q + 16'd1;
  end
  assign stat_retries = stat_q;
`else
  assign stat_retries = 16'd0;
`endif
endmodule

// File: tb/tb_uart_job_dispatch.sv
// Directed bench for uart_job_dispatch: a busy-modelling uart echo plus hand-built
// expected frames; covers ack, resend, timeout, nonce, invalid, gap abort and mid-frame reset.
module tb_uart_job_dispatch;
  localparam int RESP_TO = 400;
  localparam int GAP_TO  = 50;
`ifdef UART_JOB_DISPATCH_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic         comm_clk = 1'b0;
  logic         reset = 1'b1;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [415:0] job = '0;
  logic [7:0]   tx_byte;
  logic         transmit;
  logic         is_transmitting = 1'b0;
  logic         received = 1'b0;
  logic [7:0]   rx_byte = 8'h00;
  logic         nonce_valid;
  logic [31:0]  nonce;
  logic         job_acked;
  logic         job_failed;
  logic [15:0]  stat_retries;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int nonce_cnt = 0;
  int acked_cnt = 0;
  int failed_cnt = 0;
  int size_at = 0;
  int frame_gap = 0;
  logic [7:0]   tx_log[$];
  int           tx_cyc[$];
  logic [7:0]   exp_frame[60];
  logic [415:0] job_a, job_b;

  uart_job_dispatch #(
    .JOB_SIZE(416), .MAX_RETRIES(3), .RESP_TIMEOUT(RESP_TO), .RX_GAP_TIMEOUT(GAP_TO)
  ) dut (
    .comm_clk(comm_clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
    .job(job), .tx_byte(tx_byte), .transmit(transmit), .is_transmitting(is_transmitting),
    .received(received), .rx_byte(rx_byte), .nonce_valid(nonce_valid), .nonce(nonce),
    .job_acked(job_acked), .job_failed(job_failed), .stat_retries(stat_retries)
  );

  always #5 comm_clk = ~comm_clk;

  // Uart model and pulse monitor, sampled on the falling edge.
  always @(negedge comm_clk) begin
    cyc++;
    if (busy_cnt > 0) busy_cnt--;
    if (transmit) begin
      tx_log.push_back(tx_byte);
      tx_cyc.push_back(cyc);
      busy_cnt = 3;
    end
    is_transmitting = (busy_cnt != 0);
    if (nonce_valid) nonce_cnt++;
    if (job_acked)   acked_cnt++;
    if (job_failed)  failed_cnt++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--)
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
      else              r = {r[30:0], 1'b0};
    return r;
  endfunction

  function automatic logic [31:0] crc_over(input int base, input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < n; k++) c = crc_step(c, tx_log[base + k]);
    return c;
  endfunction

  function automatic int frame_errors(input int base);
    int e;
    e = 0;
    for (int k = 0; k < 60; k++) if (tx_log[base + k] !== exp_frame[k]) e++;
    return e;
  endfunction

  task automatic build_frame(input logic [415:0] j);
    logic [31:0] c;
    exp_frame[0] = 8'd60;
    exp_frame[1] = 8'h00;
    exp_frame[2] = 8'h00;
    exp_frame[3] = 8'd2;
    for (int k = 0; k < 52; k++) exp_frame[4 + k] = j[8*k +: 8];
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < 56; k++) c = crc_step(c, exp_frame[k]);
    exp_frame[56] = c[31:24];
    exp_frame[57] = c[23:16];
    exp_frame[58] = c[15:8];
    exp_frame[59] = c[7:0];
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge comm_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fails++;
        $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic [415:0] j);
    build_frame(j);
    tx_log.delete();
    tx_cyc.delete();
    job = j;
    job_valid = 1'b1;
    for (int c = 0; c < 50 && !job_ready; c++) tick(1);
    checkOutput("job_ready_offer", 64'(job_ready), 64'd1);
    tick(1);
    job_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    received = 1'b1;
    rx_byte = b;
    tick(1);
    received = 1'b0;
  endtask

  task automatic send_msg(input logic [63:0] m);
    for (int i = 7; i >= 0; i--) send_rx(m[8*i +: 8]);
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int c = 0; c < budget && tx_log.size() < n; c++) tick(1);
    checkOutput("tx_count_reached", 64'(tx_log.size() >= n), 64'd1);
  endtask

  initial begin
    job_a = {256'h0102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F20,
             96'hAABBCCDDEEFF001122334455, 32'h0000_0000, 32'hFFFF_FFFF};
    job_b = {256'hF0E1D2C3B4A5968778695A4B3C2D1E0F00112233445566778899AABBCCDDEEFF,
             96'h0123456789ABCDEF13572468, 32'h1000_0000, 32'h1234_5678};

    $display("[TB] reset");
    reset = 1'b1;
    tick(3);
    checkOutput("reset_job_ready", 64'(job_ready), 64'd0);
    checkOutput("reset_transmit", 64'(transmit), 64'd0);
    checkOutput("reset_tx_byte", 64'(tx_byte), 64'd0);
    reset = 1'b0;
    tick(1);
    checkOutput("ready_after_reset", 64'(job_ready), 64'd1);
    checkOutput("reset_nonce", 64'(nonce), 64'd0);
    checkOutput("reset_stat", 64'(stat_retries), 64'd0);
    checkOutput("reset_pulses", 64'({nonce_valid, job_acked, job_failed}), 64'd0);

    $display("[TB] single job, ack");
    applyStimulus(job_a);
    checkOutput("busy_not_ready", 64'(job_ready), 64'd0);
    wait_tx(60, 2000);
    tick(3);
    checkOutput("t1_bytes", 64'(tx_log.size()), 64'd60);
    checkOutput("t1_header", 64'({tx_log[0], tx_log[1], tx_log[2], tx_log[3]}), 64'h3C00_0002);
    checkOutput("t1_nonce_fields", 64'({tx_log[4], tx_log[5], tx_log[6], tx_log[7],
                                        tx_log[8], tx_log[9], tx_log[10], tx_log[11]}),
                64'hFFFF_FFFF_0000_0000);
    checkOutput("t1_payload_edges", 64'({tx_log[12], tx_log[23], tx_log[24], tx_log[55]}), 64'h55AA_2001);
    checkOutput("t1_frame", 64'(frame_errors(0)), 64'd0);
    checkOutput("t1_residual_crc", 64'(crc_over(0, 60)), 64'd0);
    send_rx(8'h01);
    for (int c = 0; c < 20 && acked_cnt < 1; c++) tick(1);
    checkOutput("t1_acked", 64'(acked_cnt), 64'd1);
    checkOutput("t1_ready_after_ack", 64'(job_ready), 64'd1);
    checkOutput("t1_no_fail", 64'(failed_cnt), 64'd0);

    $display("[TB] resend twice then ack");
    applyStimulus(job_b);
    wait_tx(60, 2000);
    tick(2);
    send_msg(64'h0800_0005_1111_2222);
    wait_tx(120, 2000);
    tick(2);
    send_msg(64'h0800_0005_3333_4444);
    wait_tx(180, 2000);
    tick(2);
    send_rx(8'h01);
    for (int c = 0; c < 20 && acked_cnt < 2; c++) tick(1);
    checkOutput("t2_bytes", 64'(tx_log.size()), 64'd180);
    checkOutput("t2_frame2", 64'(frame_errors(60)), 64'd0);
    checkOutput("t2_frame3", 64'(frame_errors(120)), 64'd0);
    checkOutput("t2_residual_crc3", 64'(crc_over(120, 60)), 64'd0);
    checkOutput("t2_acked", 64'(acked_cnt), 64'd2);
    checkOutput("t2_stat", 64'(stat_retries), 64'(2 * STATS));

    $display("[TB] no response, retries exhausted");
    applyStimulus(job_a);
    wait_tx(240, 5000);
    for (int c = 0; c < 1000 && failed_cnt < 1; c++) tick(1);
    checkOutput("t3_bytes", 64'(tx_log.size()), 64'd240);
    checkOutput("t3_failed", 64'(failed_cnt), 64'd1);
    frame_gap = tx_cyc[60] - tx_cyc[59];
    checkOutput("t3_timeout_gap", 64'(frame_gap >= RESP_TO && frame_gap <= RESP_TO + 8), 64'd1);
    checkOutput("t3_frame4", 64'(frame_errors(180)), 64'd0);
    checkOutput("t3_stat", 64'(stat_retries), 64'(5 * STATS));
    tick(RESP_TO + 50);
    checkOutput("t3_no_extra_frame", 64'(tx_log.size()), 64'd240);
    checkOutput("t3_ready", 64'(job_ready), 64'd1);

    $display("[TB] nonce during send");
    applyStimulus(job_b);
    wait_tx(10, 300);
    send_msg(64'h0800_0003_DEAD_BEEF);
    tick(2);
    checkOutput("t4_nonce_pulse", 64'(nonce_cnt), 64'd1);
    checkOutput("t4_nonce_value", 64'(nonce), 64'hDEAD_BEEF);
    wait_tx(60, 2000);
    tick(2);
    checkOutput("t4_frame_intact", 64'(frame_errors(0)), 64'd0);
    send_rx(8'h01);
    for (int c = 0; c < 20 && acked_cnt < 3; c++) tick(1);
    checkOutput("t4_acked", 64'(acked_cnt), 64'd3);
    checkOutput("t4_nonce_held", 64'(nonce), 64'hDEAD_BEEF);

    $display("[TB] gap abort, invalid, stray ack");
    applyStimulus(job_a);
    wait_tx(60, 2000);
    tick(2);
    send_rx(8'h08);
    send_rx(8'h00);
    tick(GAP_TO + 5);
    send_msg(64'h0800_0001_0000_0000);
    for (int c = 0; c < 50 && failed_cnt < 2; c++) tick(1);
    checkOutput("t5_invalid_failed", 64'(failed_cnt), 64'd2);
    tick(RESP_TO + 20);
    checkOutput("t5_no_retry", 64'(tx_log.size()), 64'd60);
    checkOutput("t5_stat", 64'(stat_retries), 64'(5 * STATS));
    send_rx(8'h01);
    tick(5);
    checkOutput("t5_stray_ack_dropped", 64'(acked_cnt), 64'd3);
    checkOutput("t5_ready", 64'(job_ready), 64'd1);

    $display("[TB] reset mid-frame");
    applyStimulus(job_b);
    wait_tx(30, 500);
    reset = 1'b1;
    tick(2);
    checkOutput("t6_transmit_in_reset", 64'(transmit), 64'd0);
    checkOutput("t6_ready_in_reset", 64'(job_ready), 64'd0);
    reset = 1'b0;
    tick(1);
    size_at = tx_log.size();
    checkOutput("t6_ready_after", 64'(job_ready), 64'd1);
    checkOutput("t6_nonce_cleared", 64'(nonce), 64'd0);
    checkOutput("t6_stat_cleared", 64'(stat_retries), 64'd0);
    tick(20);
    checkOutput("t6_no_strobes", 64'(tx_log.size()), 64'(size_at));
    applyStimulus(job_a);
    wait_tx(60, 2000);
    tick(2);
    checkOutput("t6_first_byte", 64'(tx_log[0]), 64'h3C);
    checkOutput("t6_frame", 64'(frame_errors(0)), 64'd0);
    send_rx(8'h01);
    for (int c = 0; c < 20 && acked_cnt < 4; c++) tick(1);
    checkOutput("t6_acked", 64'(acked_cnt), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
